stage_sched: RTL and testbench
==============================

STAGE_SCHED -- requirements
Module: stage_sched

Interface
REQ-001 SHALL have parameter MAX_LANDMARK, default 500, meaning the landmark capacity of the map.
REQ-002 SHALL have parameter LM_W, default 9, meaning the landmark index width, with MAX_LANDMARK <= 2^LM_W.
REQ-003 SHALL have parameter QDEPTH, default 4, meaning request queue depth (power of 2).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 4096, meaning the watchdog limit in cycles.
REQ-005 SHALL have port clk, input, 1, meaning the single clock.
REQ-006 SHALL have port sys_rst, input, 1, meaning reset, asynchronous and active-low.
REQ-007 SHALL have port req_val, input, 1, meaning host request valid.
REQ-008 SHALL have port req_rdy, output, 1, meaning queue not full.
REQ-009 SHALL have port req_stage, input, 3, meaning one-hot stage: PRD 001, NEW 010, UPD 100.
REQ-010 SHALL have port req_lm, input, LM_W, meaning landmark index for NEW/UPD, ignored for PRD.
REQ-011 SHALL have port stage_val, output, 3, meaning one-hot stage issued to the PE configurator.
REQ-012 SHALL have port stage_rdy, input, 3, meaning configurator status: 111 READY, 000 BUSY.
REQ-013 SHALL have port cur_lm, output, LM_W, meaning landmark index of the issued stage, held while issued.
REQ-014 SHALL have port lm_cnt, output, LM_W+1, meaning the number of committed landmarks.
REQ-015 SHALL have port done, output, 1, meaning a one-cycle pulse on stage completion.
REQ-016 SHALL have port reject, output, 1, meaning a one-cycle pulse when an illegal request is dropped.
REQ-017 SHALL have port timeout, output, 1, meaning a sticky watchdog flag, present only under the macro.

Function
REQ-018 A request SHALL be enqueued when req_val && req_rdy; req_rdy = (queue count < QDEPTH); enqueue and dequeue in the same cycle SHALL be allowed when full.
REQ-019 The FSM SHALL have states IDLE, CHECK, ISSUE, WAIT, DONE.
REQ-020 IDLE -> CHECK SHALL occur when the queue is non-empty; the head SHALL be popped on entering CHECK.
REQ-021 CHECK SHALL reject when req_stage is not one-hot, NEW has lm != lm_cnt, NEW has lm_cnt == MAX_LANDMARK, or UPD has lm >= lm_cnt; on reject, reject SHALL pulse and the FSM SHALL return to IDLE.
REQ-022 A legal request SHALL go CHECK -> ISSUE, driving stage_val = req_stage and cur_lm = req_lm.
REQ-023 ISSUE SHALL hold stage_val until stage_rdy == 000 is sampled, then go to WAIT with stage_val = 000 in that same transition.
REQ-024 WAIT -> DONE SHALL occur on stage_rdy == 111; DONE SHALL pulse done for one cycle, increment lm_cnt if the stage was NEW, then go to IDLE.
REQ-025 Minimum issue-to-done latency SHALL be 3 cycles after stage_rdy goes BUSY; back-to-back requests SHALL incur one IDLE cycle.
REQ-026 Stage_rdy values other than 000/111 SHALL be treated as neither BUSY nor READY, so the FSM stays in its current state.
REQ-027 lm_cnt SHALL saturate at MAX_LANDMARK and never wrap.

Reset
REQ-028 While sys_rst is low: FSM = IDLE, queue empty, stage_val = 000, cur_lm = 0, lm_cnt = 0, done = 0, reject = 0, timeout = 0, req_rdy = 0.
REQ-029 req_rdy SHALL go to 1 in the first cycle after reset release.
REQ-030 Reset asserted mid-stage SHALL abort without a done pulse and discard all queued requests.

Configuration
REQ-031 With STAGE_SCHED_TIMEOUT_EN defined: a counter SHALL run in ISSUE/WAIT; at TIMEOUT_CYC it SHALL set timeout (cleared only by reset), drop stage_val, and return to IDLE without done or an lm_cnt update.
REQ-032 Without STAGE_SCHED_TIMEOUT_EN: there SHALL be no counter, and the timeout port SHALL be tied to 0.

Structure
REQ-033 A shared package SHALL hold the stage encodings (IDLE 000, PRD 001, NEW 010, UPD 100, BUSY 000, READY 111) and the FSM state typedef.
REQ-034 The queue SHALL be sub-module stage_req_fifo, a synchronous FIFO of width 3+LM_W.

Verification
REQ-035 Bench SHALL cover: PRD request; stage_rdy 111->000 after 2 cycles, 000->111 after 10 -> stage_val 001 for 2+ cycles, done pulses once, lm_cnt stays 0.
REQ-036 Bench SHALL cover: NEW lm=0, then NEW lm=0 again -> first completes with lm_cnt = 1; second pulses reject and no stage_val is issued.
REQ-037 Bench SHALL cover: UPD lm=3 with lm_cnt = 1 -> reject pulse, FSM back in IDLE.
REQ-038 Bench SHALL cover: 5 requests pushed in consecutive cycles while the engine stays BUSY -> req_rdy = 0 after the 4th queued entry; all execute in FIFO order.
REQ-039 Bench SHALL cover: sys_rst low during WAIT -> stage_val = 000, queue empty, no done pulse.
REQ-040 Bench SHALL cover, with the macro and TIMEOUT_CYC = 16: stage_rdy held at 000 -> timeout = 1 at cycle 16 of ISSUE/WAIT, FSM in IDLE.

Source files
------------

// File: rtl/stage_sched_pkg.sv
// Shared encodings for the stage scheduler: one-hot stage codes, configurator
// handshake values and the scheduler FSM state type.
package stage_sched_pkg;

  localparam int unsigned STAGE_W = 3;

  localparam logic [STAGE_W-1:0] STG_IDLE = 3'b000;
  localparam logic [STAGE_W-1:0] STG_PRD  = 3'b001;
  localparam logic [STAGE_W-1:0] STG_NEW  = 3'b010;
  localparam logic [STAGE_W-1:0] STG_UPD  = 3'b100;

  localparam logic [STAGE_W-1:0] RDY_BUSY  = 3'b000;
  localparam logic [STAGE_W-1:0] RDY_READY = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/stage_req_fifo.sv
// Request queue for the stage scheduler: synchronous show-ahead FIFO that
// accepts a write while full when the head is popped in the same cycle.
module stage_req_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             empty_c,
  output logic             space_nxt_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             wr_en;
  logic             rd_en;

  assign rd_en       = pop && (count != '0);
  assign wr_en       = push && ((count < CW'(DEPTH)) || rd_en);
  assign count_nxt   = count + CW'(wr_en) - CW'(rd_en);
  assign rd_data_c   = mem[rd_ptr];
  assign empty_c     = (count == '0);
  assign space_nxt_c = (count_nxt < CW'(DEPTH));

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/stage_sched.sv
// Stage scheduler: queues PRD/NEW/UPD requests, checks them against the
// landmark count, and handshakes each legal stage with the PE configurator.
// Optional watchdog enabled by defining STAGE_SCHED_TIMEOUT_EN.
module stage_sched
  import stage_sched_pkg::*;
#(
  parameter int unsigned MAX_LANDMARK = 500,
  parameter int unsigned LM_W         = 9,
  parameter int unsigned QDEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC  = 4096
) (
  input  logic            clk,
  input  logic            sys_rst,
  input  logic            req_val,
  output logic            req_rdy,
  input  logic [2:0]      req_stage,
  input  logic [LM_W-1:0] req_lm,
  output logic [2:0]      stage_val,
  input  logic [2:0]      stage_rdy,
  output logic [LM_W-1:0] cur_lm,
  output logic [LM_W:0]   lm_cnt,
  output logic            done,
  output logic            reject,
  output logic            timeout
);

  localparam int unsigned CNT_W  = LM_W + 1;
  localparam int unsigned FIFO_W = STAGE_W + LM_W;
  localparam logic [CNT_W-1:0] LM_MAX = CNT_W'(MAX_LANDMARK);

  if (MAX_LANDMARK > (1 << LM_W)) begin : g_bad_lm
    $error("stage_sched: MAX_LANDMARK exceeds 2**LM_W");
  end
  if ((QDEPTH < 2) || ((QDEPTH & (QDEPTH - 1)) != 0)) begin : g_bad_qdepth
    $error("stage_sched: QDEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("stage_sched: TIMEOUT_CYC must be nonzero");
  end

  state_t            state, state_d;
  logic [2:0]        head_stage, head_stage_d;
  logic [LM_W-1:0]   head_lm, head_lm_d;
  logic [2:0]        stage_val_d;
  logic [LM_W-1:0]   cur_lm_d;
  logic [CNT_W-1:0]  lm_cnt_d;
  logic              done_d;
  logic              reject_d;
  logic              pop_c;
  logic              legal_c;
  logic              push_c;
  logic [FIFO_W-1:0] fifo_rd_c;
  logic              fifo_empty_c;
  logic              fifo_space_nxt_c;

  assign push_c = req_val && req_rdy;

  stage_req_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (sys_rst),
    .push        (push_c),
    .wr_data     ({req_stage, req_lm}),
    .pop         (pop_c),
    .rd_data_c   (fifo_rd_c),
    .empty_c     (fifo_empty_c),
    .space_nxt_c (fifo_space_nxt_c)
  );

  // Legality of the popped request against the current landmark count.
  always_comb begin
    legal_c = 1'b0;
    case (head_stage)
      STG_PRD: legal_c = 1'b1;
      STG_NEW: legal_c = (CNT_W'(head_lm) == lm_cnt) && (lm_cnt < LM_MAX);
      STG_UPD: legal_c = (CNT_W'(head_lm) < lm_cnt);
      default: legal_c = 1'b0;
    endcase
  end

`ifdef STAGE_SCHED_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt, to_cnt_d;
  logic            timeout_d;
`endif

  always_comb begin
    state_d      = state;
    head_stage_d = head_stage;
    head_lm_d    = head_lm;
    stage_val_d  = stage_val;
    cur_lm_d     = cur_lm;
    lm_cnt_d     = lm_cnt;
    done_d       = 1'b0;
    reject_d     = 1'b0;
    pop_c        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty_c) begin
          pop_c        = 1'b1;
          head_stage_d = fifo_rd_c[FIFO_W-1 -: STAGE_W];
          head_lm_d    = fifo_rd_c[LM_W-1:0];
          state_d      = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (legal_c) begin
          stage_val_d = head_stage;
          cur_lm_d    = head_lm;
          state_d     = ST_ISSUE;
        end else begin
          reject_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (stage_rdy == RDY_BUSY) begin
          stage_val_d = STG_IDLE;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (stage_rdy == RDY_READY) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
          if ((head_stage == STG_NEW) && (lm_cnt < LM_MAX)) lm_cnt_d = lm_cnt + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef STAGE_SCHED_TIMEOUT_EN
    // Watchdog overrides the handshake: abandon the stage with no completion.
    to_cnt_d  = '0;
    timeout_d = timeout;
    if ((state == ST_ISSUE) || (state == ST_WAIT)) begin
      if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
        timeout_d   = 1'b1;
        stage_val_d = STG_IDLE;
        done_d      = 1'b0;
        lm_cnt_d    = lm_cnt;
        state_d     = ST_IDLE;
      end else begin
        to_cnt_d = to_cnt + TO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= ST_IDLE;
      head_stage <= STG_IDLE;
      head_lm    <= '0;
      stage_val  <= STG_IDLE;
      cur_lm     <= '0;
      lm_cnt     <= '0;
      done       <= 1'b0;
      reject     <= 1'b0;
      req_rdy    <= 1'b0;
    end else begin
      state      <= state_d;
      head_stage <= head_stage_d;
      head_lm    <= head_lm_d;
      stage_val  <= stage_val_d;
      cur_lm     <= cur_lm_d;
      lm_cnt     <= lm_cnt_d;
      done       <= done_d;
      reject     <= reject_d;
      req_rdy    <= fifo_space_nxt_c;
    end
  end

`ifdef STAGE_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      to_cnt  <= to_cnt_d;
      timeout <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_stage_sched.sv
// Self-checking bench for stage_sched: directed scenarios plus randomized
// request batches checked against a request-level model of the scheduler.
module tb_stage_sched;

  localparam int unsigned LM_W = 3;
  localparam int unsigned MAXL = 6;
  localparam int unsigned QD   = 4;
  localparam int unsigned TO   = 16;

  typedef struct {
    logic [2:0]      st;
    logic [LM_W-1:0] lm;
  } req_t;

  logic            clk = 1'b0;
  logic            sys_rst = 1'b0;
  logic            req_val = 1'b0;
  logic            req_rdy;
  logic [2:0]      req_stage = 3'b000;
  logic [LM_W-1:0] req_lm = '0;
  logic [2:0]      stage_val;
  logic [2:0]      stage_rdy = 3'b111;
  logic [LM_W-1:0] cur_lm;
  logic [LM_W:0]   lm_cnt;
  logic            done;
  logic            reject;
  logic            timeout;

  stage_sched #(
    .MAX_LANDMARK (MAXL),
    .LM_W         (LM_W),
    .QDEPTH       (QD),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_stage (req_stage),
    .req_lm    (req_lm),
    .stage_val (stage_val),
    .stage_rdy (stage_rdy),
    .cur_lm    (cur_lm),
    .lm_cnt    (lm_cnt),
    .done      (done),
    .reject    (reject),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, reject_cnt = 0, issue_cnt = 0, sv_cycles = 0;
  logic [2:0] prev_sv = 3'b000;

  // Model state: pending requests, committed landmarks, expected event totals.
  req_t model_q[$];
  int   model_cnt = 0;
  int   exp_done = 0, exp_reject = 0, exp_issue = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (reject) reject_cnt++;
    if ((stage_val != 3'b000) && (prev_sv == 3'b000)) issue_cnt++;
    if (stage_val != 3'b000) sv_cycles++;
    prev_sv = stage_val;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit legal(input logic [2:0] st, input int lm, input int cnt);
    case (st)
      3'b001:  return 1'b1;
      3'b010:  return (lm == cnt) && (cnt < int'(MAXL));
      3'b100:  return lm < cnt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic send(input logic [2:0] st, input logic [LM_W-1:0] lm);
    int n = 0;
    req_t r;
    while (!req_rdy && n < 100) begin tick(1); n++; end
    if (n >= 100) chk("push_rdy_timeout", 32'(req_rdy), 32'd1);
    req_val = 1'b1; req_stage = st; req_lm = lm;
    tick(1);
    req_val = 1'b0;
    r.st = st; r.lm = lm;
    model_q.push_back(r);
  endtask

  task automatic wait_issue();
    int n = 0;
    while (stage_val == 3'b000 && n < 30) begin tick(1); n++; end
    if (n >= 30) chk("issue_wait_timeout", 32'(stage_val), 32'hFFFF);
  endtask

  // Play the configurator for one issued stage and check its completion.
  task automatic serve(input req_t r, input int hold, input int busy);
    int n;
    wait_issue();
    exp_issue++;
    chk("issue_stage", 32'(stage_val), 32'(r.st));
    chk("issue_lm", 32'(cur_lm), 32'(r.lm));
    tick(hold);
    chk("issue_hold", 32'(stage_val), 32'(r.st));
    stage_rdy = 3'b000;
    tick(1);
    chk("issue_drop", 32'(stage_val), 32'd0);
    tick(busy - 1);
    stage_rdy = 3'b111;
    exp_done++;
    n = 0;
    while (done_cnt < exp_done && n < 20) begin tick(1); n++; end
    tick(2);
    chk("done_count", 32'(done_cnt), 32'(exp_done));
    chk("issue_count", 32'(issue_cnt), 32'(exp_issue));
  endtask

  task automatic expect_reject();
    int n = 0;
    exp_reject++;
    while (reject_cnt < exp_reject && n < 20) begin tick(1); n++; end
    tick(1);
    chk("reject_count", 32'(reject_cnt), 32'(exp_reject));
    chk("reject_no_issue", 32'(issue_cnt), 32'(exp_issue));
  endtask

  task automatic do_one(input int hold, input int busy);
    req_t r;
    r = model_q.pop_front();
    if (legal(r.st, int'(r.lm), model_cnt)) begin
      serve(r, hold, busy);
      if (r.st == 3'b010 && model_cnt < int'(MAXL)) model_cnt++;
    end else begin
      expect_reject();
    end
    chk("lm_cnt", 32'(lm_cnt), 32'(model_cnt));
  endtask

  task automatic drain();
    while (model_q.size() > 0)
      do_one(int'($urandom_range(0, 3)), int'($urandom_range(1, 8)));
  endtask

  initial begin : main
    req_t r;
    int n, s0, proj, k, nreq;
    logic [2:0] st;
    logic [2:0] bad [5];
    bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b101; bad[3] = 3'b110; bad[4] = 3'b111;

    // Reset values.
    tick(2);
    chk("rst_stage_val", 32'(stage_val), 32'd0);
    chk("rst_cur_lm", 32'(cur_lm), 32'd0);
    chk("rst_lm_cnt", 32'(lm_cnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_reject", 32'(reject), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    sys_rst = 1'b1;
    tick(1);
    chk("req_rdy_after_rst", 32'(req_rdy), 32'd1);

    // PRD: ready held 2 cycles, busy 10 cycles.
    s0 = sv_cycles;
    send(3'b001, 3'd5);
    do_one(2, 10);
    chk("prd_held_2plus", 32'(sv_cycles - s0 >= 2), 32'd1);
    chk("prd_lm_cnt", 32'(lm_cnt), 32'd0);

    // NEW lm=0 twice: first commits, second is rejected.
    send(3'b010, 3'd0);
    send(3'b010, 3'd0);
    drain();
    chk("new_lm_cnt", 32'(lm_cnt), 32'd1);

    // UPD beyond the committed count, then a PRD proves the FSM is idle again.
    send(3'b100, 3'd3);
    drain();
    send(3'b001, 3'd2);
    drain();

    // Queue fill while the engine is stuck busy.
    stage_rdy = 3'b000;
    send(3'b001, 3'd1);
    send(3'b100, 3'd0);
    send(3'b001, 3'd4);
    send(3'b010, 3'd1);
    send(3'b001, 3'd6);
    chk("full_req_rdy", 32'(req_rdy), 32'd0);
    tick(3);
    chk("full_req_rdy_hold", 32'(req_rdy), 32'd0);
    r = model_q.pop_front();
    exp_issue++;
    exp_done++;
    stage_rdy = 3'b111;
    n = 0;
    while (done_cnt < exp_done && n < 20) begin tick(1); n++; end
    chk("full_first_done", 32'(done_cnt), 32'(exp_done));
    drain();
    chk("full_lm_cnt", 32'(lm_cnt), 32'd2);

    // Randomized batches.
    for (int b = 0; b < 14; b++) begin
      nreq = int'($urandom_range(1, 3));
      proj = model_cnt;
      for (int i = 0; i < nreq; i++) begin
        k = int'($urandom_range(0, 9));
        if (k < 3) begin
          send(3'b001, LM_W'($urandom));
        end else if (k < 7) begin
          if ($urandom_range(0, 9) < 7) begin
            send(3'b010, LM_W'(proj));
            if (proj < int'(MAXL)) proj++;
          end else begin
            send(3'b010, LM_W'($urandom));
          end
        end else if (k < 9) begin
          send(3'b100, LM_W'($urandom_range(0, 7)));
        end else begin
          st = bad[$urandom_range(0, 4)];
          send(st, LM_W'($urandom));
        end
      end
      drain();
    end

    // Saturate the landmark map; one more NEW is rejected.
    while (model_cnt < int'(MAXL)) begin
      send(3'b010, LM_W'(model_cnt));
      drain();
    end
    send(3'b010, LM_W'(MAXL));
    drain();
    chk("sat_lm_cnt", 32'(lm_cnt), 32'(MAXL));
    send(3'b100, LM_W'(MAXL - 1));
    drain();

    // Reset in the middle of WAIT with a second request queued.
    send(3'b001, 3'd1);
    send(3'b010, 3'd0);
    wait_issue();
    exp_issue++;
    stage_rdy = 3'b000;
    tick(2);
    sys_rst = 1'b0;
    #1;
    chk("midrst_stage_val", 32'(stage_val), 32'd0);
    chk("midrst_req_rdy", 32'(req_rdy), 32'd0);
    chk("midrst_lm_cnt", 32'(lm_cnt), 32'd0);
    tick(2);
    sys_rst = 1'b1;
    stage_rdy = 3'b111;
    model_q.delete();
    model_cnt = 0;
    tick(8);
    chk("midrst_no_done", 32'(done_cnt), 32'(exp_done));
    chk("midrst_queue_empty", 32'(issue_cnt), 32'(exp_issue));
    chk("midrst_req_rdy_back", 32'(req_rdy), 32'd1);
    send(3'b010, 3'd0);
    drain();

`ifdef STAGE_SCHED_TIMEOUT_EN
    // Watchdog: configurator never returns READY.
    stage_rdy = 3'b000;
    send(3'b010, LM_W'(model_cnt));
    void'(model_q.pop_front());
    wait_issue();
    exp_issue++;
    tick(TO - 1);
    chk("to_not_yet", 32'(timeout), 32'd0);
    tick(1);
    chk("to_set", 32'(timeout), 32'd1);
    chk("to_stage_val", 32'(stage_val), 32'd0);
    tick(3);
    chk("to_no_done", 32'(done_cnt), 32'(exp_done));
    chk("to_lm_cnt", 32'(lm_cnt), 32'(model_cnt));
    stage_rdy = 3'b111;
    send(3'b001, 3'd0);
    drain();
    chk("to_sticky", 32'(timeout), 32'd1);
`else
    chk("timeout_tied_low", 32'(timeout), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
